// File: rtl/bank_pkg.sv
// Shared bank-side types and constants: opcode encodings, request field widths
// and the request payload struct carried from crossbar channels to the HTU.
package bank_pkg;

  localparam int NUM_CH    = 3;
  localparam int CH_ID_W   = 2;
  localparam int ADDR_HI   = 31;
  localparam int ADDR_LO   = 4;
  localparam int ADDR_W    = ADDR_HI - ADDR_LO + 1;
  localparam int WBUF_ID_W = 8;
  localparam int OPC_W     = 2;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OPC_READ  = 2'b00;
  localparam opcode_t OPC_WRITE = 2'b01;

  typedef struct packed {
    opcode_t               opcode;
    logic [ADDR_W-1:0]     addr;
    logic [WBUF_ID_W-1:0]  wbuffer_id;
  } req_payload_t;

  // Round-robin successor of a channel id: 0 -> 1 -> 2 -> 0.
  function automatic logic [CH_ID_W-1:0] next_ch(input logic [CH_ID_W-1:0] k);
    return (k == CH_ID_W'(NUM_CH - 1)) ? '0 : k + 1'b1;
  endfunction

endpackage

// File: rtl/bank_rr_arbiter3.sv
// Combinational three-way round-robin: first eligible channel at or after
// rr_ptr wins, plus the pointer value that follows that winner.
module bank_rr_arbiter3
  import bank_pkg::*;
(
  input  logic [NUM_CH-1:0]  elig,
  input  logic [CH_ID_W-1:0] rr_ptr,
  output logic [NUM_CH-1:0]  grant,
  output logic [CH_ID_W-1:0] grant_id,
  output logic [CH_ID_W-1:0] next_ptr
);

  logic found;
  int   idx;

  always_comb begin
    // NOTE: every output and temporary gets a default up front so no path
    // through the search loop can leave a value unassigned and infer a latch.
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = CH_ID_W'(idx);
      end
    end
    next_ptr = next_ch(grant_id);
  end

endmodule

// File: rtl/bank_req_arbiter.sv
// Shares one bank HTU request port among three crossbar channels with
// round-robin arbitration and per-channel read-return credits.
// Optional BANK_REQ_ARB_PERF_EN adds grant/stall performance counters.
module bank_req_arbiter
  import bank_pkg::*;
#(
  parameter int CREDIT_NUM = 4,
  parameter int CNT_W      = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CH-1:0]           ch_req_valid_i,
  output logic [NUM_CH-1:0]           ch_req_ready_o,
  input  logic [NUM_CH*OPC_W-1:0]     ch_req_opcode_i,
  input  logic [NUM_CH*ADDR_W-1:0]    ch_req_addr_i,
  input  logic [NUM_CH*WBUF_ID_W-1:0] ch_req_wbuffer_id_i,
  output logic                        htu_valid_o,
  input  logic                        htu_allowIn_i,
  output logic [CH_ID_W-1:0]          htu_ch_id_o,
  output logic [OPC_W-1:0]            htu_opcode_o,
  output logic [ADDR_W-1:0]           htu_addr_o,
  output logic [WBUF_ID_W-1:0]        htu_wbuffer_id_o,
  input  logic                        rtn_valid_i,
  input  logic [CH_ID_W-1:0]          rtn_channel_id_i,
  output logic [NUM_CH*CNT_W-1:0]     credit_o,
  output logic                        credit_err_o
`ifdef BANK_REQ_ARB_PERF_EN
  ,
  input  logic                        perf_clr_i,
  output logic [NUM_CH*16-1:0]        perf_grant_cnt_o,
  output logic [15:0]                 perf_stall_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CREDIT_FULL = CNT_W'(CREDIT_NUM);

  req_payload_t       ch_pay   [NUM_CH];
  logic [CNT_W-1:0]   credit_q [NUM_CH];
  logic [NUM_CH-1:0]  elig;
  logic [NUM_CH-1:0]  grant;
  logic [NUM_CH-1:0]  dec;
  logic [NUM_CH-1:0]  inc;
  logic [CH_ID_W-1:0] grant_id;
  logic [CH_ID_W-1:0] next_ptr;
  logic [CH_ID_W-1:0] rr_ptr;
  logic               load;
  logic               accept;
  req_payload_t       slot_q;

  always_comb begin
    elig     = '0;
    dec      = '0;
    inc      = '0;
    credit_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_pay[k].opcode     = ch_req_opcode_i[k*OPC_W +: OPC_W];
      ch_pay[k].addr       = ch_req_addr_i[k*ADDR_W +: ADDR_W];
      ch_pay[k].wbuffer_id = ch_req_wbuffer_id_i[k*WBUF_ID_W +: WBUF_ID_W];
      // A read needs a free return-buffer slot; every other opcode always flows.
      elig[k] = ch_req_valid_i[k] &
                ((ch_pay[k].opcode != OPC_READ) | (credit_q[k] != '0));
      dec[k]  = ch_req_ready_o[k] & (ch_pay[k].opcode == OPC_READ);
      inc[k]  = rtn_valid_i & (rtn_channel_id_i == CH_ID_W'(k));
      credit_o[k*CNT_W +: CNT_W] = credit_q[k];
    end
  end

  bank_rr_arbiter3 u_rr (
    .elig     (elig),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .next_ptr (next_ptr)
  );

  // The slot can take a new request when it is empty or draining this cycle.
  assign load           = ~htu_valid_o | htu_allowIn_i;
  assign ch_req_ready_o = grant & {NUM_CH{load & ~rst_i}};
  assign accept         = |ch_req_ready_o;

  assign htu_opcode_o     = slot_q.opcode;
  assign htu_addr_o       = slot_q.addr;
  assign htu_wbuffer_id_o = slot_q.wbuffer_id;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      htu_valid_o <= 1'b0;
      htu_ch_id_o <= '0;
      slot_q      <= '0;
      rr_ptr      <= '0;
    end else begin
      if (load) begin
        htu_valid_o <= accept;
        if (accept) begin
          slot_q      <= ch_pay[grant_id];
          htu_ch_id_o <= grant_id;
        end
      end
      if (accept) rr_ptr <= next_ptr;
    end
  end

  // NOTE: the credit array is reset explicitly; unlike a data memory its
  // contents are control state and must start at the full allowance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CH; k++) credit_q[k] <= CREDIT_FULL;
      credit_err_o <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (dec[k] && !inc[k]) begin
          credit_q[k] <= credit_q[k] - 1'b1;
        end else if (inc[k] && !dec[k]) begin
          // A return with no outstanding read is an upstream bug: saturate, flag.
          if (credit_q[k] == CREDIT_FULL) credit_err_o <= 1'b1;
          else                            credit_q[k]  <= credit_q[k] + 1'b1;
        end
      end
    end
  end

`ifdef BANK_REQ_ARB_PERF_EN
  logic [15:0] grant_cnt_q [NUM_CH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CH; k++) grant_cnt_q[k] <= '0;
      perf_stall_cnt_o <= '0;
    end else if (perf_clr_i) begin
      for (int k = 0; k < NUM_CH; k++) grant_cnt_q[k] <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_req_ready_o[k] && grant_cnt_q[k] != '1)
          grant_cnt_q[k] <= grant_cnt_q[k] + 1'b1;
      end
      if (htu_valid_o && !htu_allowIn_i && perf_stall_cnt_o != '1)
        perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
    end
  end

  always_comb begin
    perf_grant_cnt_o = '0;
    for (int k = 0; k < NUM_CH; k++) perf_grant_cnt_o[k*16 +: 16] = grant_cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_bank_req_arbiter.sv
// Self-checking bench for bank_req_arbiter: a directed vector table for the
// arbitration/credit behaviour plus hand sequences for reset and perf counters.
module tb_bank_req_arbiter;
  import bank_pkg::*;

  localparam int CNT_W = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [2:0]   ch_req_valid_i;
  logic [2:0]   ch_req_ready_o;
  logic [5:0]   ch_req_opcode_i;
  logic [83:0]  ch_req_addr_i;
  logic [23:0]  ch_req_wbuffer_id_i;
  logic         htu_valid_o;
  logic         htu_allowIn_i;
  logic [1:0]   htu_ch_id_o;
  logic [1:0]   htu_opcode_o;
  logic [27:0]  htu_addr_o;
  logic [7:0]   htu_wbuffer_id_o;
  logic         rtn_valid_i;
  logic [1:0]   rtn_channel_id_i;
  logic [11:0]  credit_o;
  logic         credit_err_o;
`ifdef BANK_REQ_ARB_PERF_EN
  logic         perf_clr_i;
  logic [47:0]  perf_grant_cnt_o;
  logic [15:0]  perf_stall_cnt_o;
`endif

  bank_req_arbiter #(.CREDIT_NUM(4), .CNT_W(CNT_W)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .ch_req_valid_i      (ch_req_valid_i),
    .ch_req_ready_o      (ch_req_ready_o),
    .ch_req_opcode_i     (ch_req_opcode_i),
    .ch_req_addr_i       (ch_req_addr_i),
    .ch_req_wbuffer_id_i (ch_req_wbuffer_id_i),
    .htu_valid_o         (htu_valid_o),
    .htu_allowIn_i       (htu_allowIn_i),
    .htu_ch_id_o         (htu_ch_id_o),
    .htu_opcode_o        (htu_opcode_o),
    .htu_addr_o          (htu_addr_o),
    .htu_wbuffer_id_o    (htu_wbuffer_id_o),
    .rtn_valid_i         (rtn_valid_i),
    .rtn_channel_id_i    (rtn_channel_id_i),
    .credit_o            (credit_o),
    .credit_err_o        (credit_err_o)
`ifdef BANK_REQ_ARB_PERF_EN
    ,
    .perf_clr_i          (perf_clr_i),
    .perf_grant_cnt_o    (perf_grant_cnt_o),
    .perf_stall_cnt_o    (perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  valid;
    logic [5:0]  opc;
    logic        allow;
    logic        rtn_v;
    logic [1:0]  rtn_id;
    logic [2:0]  exp_ready;
    logic        exp_hv;
    logic [1:0]  exp_id;
    logic [11:0] exp_credit;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [27:0] addr_tab [3];
  logic [7:0]  wbuf_tab [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] valid, input logic [5:0] opc,
                              input logic allow, input logic rtn_v, input logic [1:0] rtn_id,
                              input logic [2:0] exp_ready, input logic exp_hv,
                              input logic [1:0] exp_id, input logic [11:0] exp_credit,
                              input logic exp_err);
    vec_t v;
    v.valid = valid; v.opc = opc; v.allow = allow; v.rtn_v = rtn_v; v.rtn_id = rtn_id;
    v.exp_ready = exp_ready; v.exp_hv = exp_hv; v.exp_id = exp_id;
    v.exp_credit = exp_credit; v.exp_err = exp_err;
    return v;
  endfunction

  // One cycle: drive at posedge+1, check ready mid-cycle, check registers after edge.
  task automatic cycle(input logic [2:0] valid, input logic [5:0] opc, input logic allow,
                       input logic rtn_v, input logic [1:0] rtn_id);
    ch_req_valid_i   = valid;
    ch_req_opcode_i  = opc;
    htu_allowIn_i    = allow;
    rtn_valid_i      = rtn_v;
    rtn_channel_id_i = rtn_id;
    #3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] w_all, r1, r2, r0;
    logic [1:0] exp_opc;
    logic [27:0] exp_addr;
    logic [7:0] exp_wbuf;
    int gid;

    w_all = 6'b01_01_01;  // all channels WRITE
    r1    = 6'b01_00_01;  // ch1 READ
    r2    = 6'b00_01_01;  // ch2 READ, ch0/ch1 WRITE
    r0    = 6'b01_01_00;  // ch0 READ

    addr_tab[0] = 28'h0A0_0010; addr_tab[1] = 28'h0B1_0021; addr_tab[2] = 28'h0C2_0032;
    wbuf_tab[0] = 8'hA0;        wbuf_tab[1] = 8'hB1;        wbuf_tab[2] = 8'hC2;
    ch_req_addr_i       = {addr_tab[2], addr_tab[1], addr_tab[0]};
    ch_req_wbuffer_id_i = {wbuf_tab[2], wbuf_tab[1], wbuf_tab[0]};
`ifdef BANK_REQ_ARB_PERF_EN
    perf_clr_i = 1'b0;
`endif

    // Reset state with requests already pending: no ready may escape.
    rst_i = 1'b1;
    cycle(3'b111, w_all, 1'b1, 1'b0, 2'd0);
    check("reset ready", ch_req_ready_o, 3'b000);
    check("reset htu_valid", htu_valid_o, 1'b0);
    check("reset ch_id", htu_ch_id_o, 2'd0);
    check("reset addr", htu_addr_o, 28'd0);
    check("reset credit", credit_o, 12'h444);
    check("reset err", credit_err_o, 1'b0);
    ch_req_valid_i = 3'b000;
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Round-robin with writes, then drain.
    vq.push_back(mk(3'b111, w_all, 1, 0, 0, 3'b001, 1, 0, 12'h444, 0));
    vq.push_back(mk(3'b111, w_all, 1, 0, 0, 3'b010, 1, 1, 12'h444, 0));
    vq.push_back(mk(3'b111, w_all, 1, 0, 0, 3'b100, 1, 2, 12'h444, 0));
    vq.push_back(mk(3'b111, w_all, 1, 0, 0, 3'b001, 1, 0, 12'h444, 0));
    vq.push_back(mk(3'b000, w_all, 1, 0, 0, 3'b000, 0, 0, 12'h444, 0));
    // ch1 reads until credits run out, then one return re-enables it next cycle.
    vq.push_back(mk(3'b010, r1, 1, 0, 0, 3'b010, 1, 1, 12'h434, 0));
    vq.push_back(mk(3'b010, r1, 1, 0, 0, 3'b010, 1, 1, 12'h424, 0));
    vq.push_back(mk(3'b010, r1, 1, 0, 0, 3'b010, 1, 1, 12'h414, 0));
    vq.push_back(mk(3'b010, r1, 1, 0, 0, 3'b010, 1, 1, 12'h404, 0));
    vq.push_back(mk(3'b010, r1, 1, 0, 0, 3'b000, 0, 1, 12'h404, 0));
    vq.push_back(mk(3'b010, r1, 1, 0, 0, 3'b000, 0, 1, 12'h404, 0));
    vq.push_back(mk(3'b010, r1, 1, 1, 1, 3'b000, 0, 1, 12'h414, 0));
    vq.push_back(mk(3'b010, r1, 1, 0, 0, 3'b010, 1, 1, 12'h404, 0));
    // Five stall cycles with slot full, then release loads ch2 in the same cycle.
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(3'b111, w_all, 0, 0, 0, 3'b000, 1, 1, 12'h404, 0));
    vq.push_back(mk(3'b111, w_all, 1, 0, 0, 3'b100, 1, 2, 12'h404, 0));
    // ch2 reads; accept and return together leave credit unchanged.
    vq.push_back(mk(3'b100, r2, 1, 0, 0, 3'b100, 1, 2, 12'h304, 0));
    vq.push_back(mk(3'b100, r2, 1, 0, 0, 3'b100, 1, 2, 12'h204, 0));
    vq.push_back(mk(3'b100, r2, 1, 1, 2, 3'b100, 1, 2, 12'h204, 0));
    // Overflow on full ch0, id 3 ignored, ch1 refill.
    vq.push_back(mk(3'b000, r2, 1, 1, 0, 3'b000, 0, 2, 12'h204, 1));
    vq.push_back(mk(3'b000, r2, 1, 1, 3, 3'b000, 0, 2, 12'h204, 1));
    vq.push_back(mk(3'b000, r2, 1, 1, 1, 3'b000, 0, 2, 12'h214, 1));
    // Drain ch0 credits, then ch0 WRITE interleaves with ch2 READ.
    vq.push_back(mk(3'b001, r0, 1, 0, 0, 3'b001, 1, 0, 12'h213, 1));
    vq.push_back(mk(3'b001, r0, 1, 0, 0, 3'b001, 1, 0, 12'h212, 1));
    vq.push_back(mk(3'b001, r0, 1, 0, 0, 3'b001, 1, 0, 12'h211, 1));
    vq.push_back(mk(3'b001, r0, 1, 0, 0, 3'b001, 1, 0, 12'h210, 1));
    vq.push_back(mk(3'b001, r0, 1, 0, 0, 3'b000, 0, 0, 12'h210, 1));
    vq.push_back(mk(3'b101, r2, 1, 0, 0, 3'b100, 1, 2, 12'h110, 1));
    vq.push_back(mk(3'b101, r2, 1, 0, 0, 3'b001, 1, 0, 12'h110, 1));
    vq.push_back(mk(3'b101, r2, 1, 0, 0, 3'b100, 1, 2, 12'h010, 1));
    vq.push_back(mk(3'b101, r2, 1, 0, 0, 3'b001, 1, 0, 12'h010, 1));
    vq.push_back(mk(3'b101, r2, 1, 0, 0, 3'b001, 1, 0, 12'h010, 1));

    exp_opc = '0; exp_addr = '0; exp_wbuf = '0;
    foreach (vq[i]) begin
      cycle(vq[i].valid, vq[i].opc, vq[i].allow, vq[i].rtn_v, vq[i].rtn_id);
      check($sformatf("v%0d ready", i), ch_req_ready_o, vq[i].exp_ready);
      if (vq[i].exp_ready != 3'b000) begin
        gid      = int'(vq[i].exp_id);
        exp_opc  = vq[i].opc[2*gid +: 2];
        exp_addr = addr_tab[gid];
        exp_wbuf = wbuf_tab[gid];
      end
      @(posedge clk_i); #1;
      check($sformatf("v%0d htu_valid", i), htu_valid_o, vq[i].exp_hv);
      check($sformatf("v%0d ch_id", i), htu_ch_id_o, vq[i].exp_id);
      check($sformatf("v%0d opcode", i), htu_opcode_o, exp_opc);
      check($sformatf("v%0d addr", i), htu_addr_o, exp_addr);
      check($sformatf("v%0d wbuf", i), htu_wbuffer_id_o, exp_wbuf);
      check($sformatf("v%0d credit", i), credit_o, vq[i].exp_credit);
      check($sformatf("v%0d err", i), credit_err_o, vq[i].exp_err);
    end

    // Asynchronous reset mid-operation: slot dropped, credits and error restored.
    ch_req_valid_i = 3'b101;
    rst_i = 1'b1;
    #1;
    check("midrst htu_valid", htu_valid_o, 1'b0);
    check("midrst ready", ch_req_ready_o, 3'b000);
    check("midrst credit", credit_o, 12'h444);
    check("midrst err", credit_err_o, 1'b0);
    ch_req_valid_i = 3'b000;
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Stale return after reset counts as overflow.
    cycle(3'b000, w_all, 1'b1, 1'b1, 2'd2);
    @(posedge clk_i); #1;
    check("stale rtn credit", credit_o, 12'h444);
    check("stale rtn err", credit_err_o, 1'b1);

`ifdef BANK_REQ_ARB_PERF_EN
    for (int i = 0; i < 10; i++) begin
      cycle(3'b010, w_all, 1'b1, 1'b0, 2'd0);
      @(posedge clk_i); #1;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(3'b000, w_all, 1'b0, 1'b0, 2'd0);
      @(posedge clk_i); #1;
    end
    cycle(3'b000, w_all, 1'b1, 1'b0, 2'd0);
    @(posedge clk_i); #1;
    check("perf grant ch1", perf_grant_cnt_o[31:16], 16'd10);
    check("perf grant ch0", perf_grant_cnt_o[15:0], 16'd0);
    check("perf stall", perf_stall_cnt_o, 16'd3);
    perf_clr_i = 1'b1;
    cycle(3'b010, w_all, 1'b1, 1'b0, 2'd0);
    @(posedge clk_i); #1;
    perf_clr_i = 1'b0;
    check("perf clr grant", perf_grant_cnt_o, 48'd0);
    check("perf clr stall", perf_stall_cnt_o, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
